// File: rtl/prpg_pattern_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : prpg_pattern_analyzer
// Description : Compacts a stream of 8-bit patterns into a MISR signature and
//               accumulates weight, Hamming-distance and toggle statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module prpg_pattern_analyzer #(
    parameter int unsigned     W        = 8,
    parameter int unsigned     CNT_W    = 12,
    parameter logic [W-1:0]    MISR_TAP = 8'h1D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       batch_len,
    input  logic             pat_valid,
    input  logic [W-1:0]     pat_data,
    output logic             pat_ready,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     sig,
    output logic [CNT_W-1:0] wt_sum,
    output logic [CNT_W-1:0] hd_sum,
    output logic [3:0]       hd_max,
    output logic [W-1:0]     toggle_mask
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_remaining;
    logic [W-1:0]     r_prev;
    logic             r_first;
    logic [W-1:0]     r_seen0;
    logic [W-1:0]     r_seen1;
    logic [W-1:0]     r_sig;
    logic [CNT_W-1:0] r_wt_sum;
    logic [CNT_W-1:0] r_hd_sum;
    logic [3:0]       r_hd_max;
    logic [W-1:0]     r_toggle;

    logic             w_start;
    logic             w_xfer;
    logic [3:0]       w_wt;
    logic [3:0]       w_hd;
    logic [W-1:0]     w_misr;
    logic [W-1:0]     w_seen0_next;
    logic [W-1:0]     w_seen1_next;

    function automatic logic [3:0] popcnt(input logic [W-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < W; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    assign w_start      = start && (r_state == S_IDLE);
    assign w_xfer       = pat_valid && (r_state == S_RUN);
    assign w_wt         = popcnt(pat_data);
    assign w_hd         = popcnt(pat_data ^ r_prev);
    assign w_misr       = {r_sig[W-2:0], 1'b0} ^ (r_sig[W-1] ? MISR_TAP : '0) ^ pat_data;
    assign w_seen0_next = r_seen0 | ~pat_data;
    assign w_seen1_next = r_seen1 | pat_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        pat_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (batch_len == 8'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                pat_ready = 1'b1;
                busy      = 1'b1;
                if (pat_valid && (r_remaining == 8'd1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= 8'd0;
            r_prev      <= '0;
            r_first     <= 1'b0;
            r_seen0     <= '0;
            r_seen1     <= '0;
            r_sig       <= '0;
            r_wt_sum    <= '0;
            r_hd_sum    <= '0;
            r_hd_max    <= 4'd0;
            r_toggle    <= '0;
        end else if (w_start) begin
            r_remaining <= batch_len;
            r_first     <= 1'b1;
            r_seen0     <= '0;
            r_seen1     <= '0;
            r_sig       <= '0;
            r_wt_sum    <= '0;
            r_hd_sum    <= '0;
            r_hd_max    <= 4'd0;
            r_toggle    <= '0;
        end else if (w_xfer) begin
            r_sig       <= w_misr;
            r_wt_sum    <= r_wt_sum + CNT_W'(w_wt);
            // The first pattern of a batch has no predecessor to compare with.
            if (!r_first) begin
                r_hd_sum <= r_hd_sum + CNT_W'(w_hd);
                if (w_hd > r_hd_max) begin
                    r_hd_max <= w_hd;
                end
            end
            r_seen0     <= w_seen0_next;
            r_seen1     <= w_seen1_next;
            r_toggle    <= w_seen0_next & w_seen1_next;
            r_prev      <= pat_data;
            r_first     <= 1'b0;
            r_remaining <= r_remaining - 8'd1;
        end
    end

    assign sig         = r_sig;
    assign wt_sum      = r_wt_sum;
    assign hd_sum      = r_hd_sum;
    assign hd_max      = r_hd_max;
    assign toggle_mask = r_toggle;

endmodule
`default_nettype wire

// File: tb/tb_prpg_pattern_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prpg_pattern_analyzer
// Description : Scoreboard bench: expected results queued at batch start,
//               checked by a monitor whenever done is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prpg_pattern_analyzer;

    typedef struct {
        logic [7:0]  sig;
        logic [11:0] wt;
        logic [11:0] hd;
        logic [3:0]  hmax;
        logic [7:0]  tm;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  batch_len = 8'd0;
    logic        pat_valid = 1'b0;
    logic [7:0]  pat_data = 8'd0;
    logic        pat_ready;
    logic        busy;
    logic        done;
    logic [7:0]  sig;
    logic [11:0] wt_sum;
    logic [11:0] hd_sum;
    logic [3:0]  hd_max;
    logic [7:0]  toggle_mask;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];

    prpg_pattern_analyzer #(
        .W        (8),
        .CNT_W    (12),
        .MISR_TAP (8'h1D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .batch_len   (batch_len),
        .pat_valid   (pat_valid),
        .pat_data    (pat_data),
        .pat_ready   (pat_ready),
        .busy        (busy),
        .done        (done),
        .sig         (sig),
        .wt_sum      (wt_sum),
        .hd_sum      (hd_sum),
        .hd_max      (hd_max),
        .toggle_mask (toggle_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] s, input logic [11:0] w, input logic [11:0] h,
                            input logic [3:0] m, input logic [7:0] t);
        res_t r;
        r.sig = s; r.wt = w; r.hd = h; r.hmax = m; r.tm = t;
        exp_q.push_back(r);
    endtask

    task automatic start_batch(input logic [7:0] len);
        start     = 1'b1;
        batch_len = len;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        pat_valid = 1'b1;
        pat_data  = d;
        @(negedge clk);
        pat_valid = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                chk("sb_sig",  {24'd0, sig},         {24'd0, r.sig});
                chk("sb_wt",   {20'd0, wt_sum},      {20'd0, r.wt});
                chk("sb_hd",   {20'd0, hd_sum},      {20'd0, r.hd});
                chk("sb_hmax", {28'd0, hd_max},      {28'd0, r.hmax});
                chk("sb_tm",   {24'd0, toggle_mask}, {24'd0, r.tm});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: asynchronous reset
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pat_ready", {31'd0, pat_ready}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        chk("rst_sig",       {24'd0, sig},       32'd0);
        chk("rst_wt",        {20'd0, wt_sum},    32'd0);
        chk("rst_hd",        {20'd0, hd_sum},    32'd0);
        chk("rst_hmax",      {28'd0, hd_max},    32'd0);
        chk("rst_tm",        {24'd0, toggle_mask}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: three back-to-back patterns
        push_exp(8'hEC, 12'd12, 12'd12, 4'd8, 8'hFF);
        start_batch(8'd3);
        chk("c2_ready", {31'd0, pat_ready}, 32'd1);
        send(8'h00);
        send(8'hFF);
        send(8'h0F);
        chk("c2_done", {31'd0, done}, 32'd1);
        chk("c2_busy_in_done", {31'd0, busy}, 32'd1);
        chk("c2_ready_in_done", {31'd0, pat_ready}, 32'd0);
        @(negedge clk);
        chk("c2_done_low", {31'd0, done}, 32'd0);
        chk("c2_busy_low", {31'd0, busy}, 32'd0);

        // 6: results hold in IDLE while pat_valid toggles activity
        pat_valid = 1'b1;
        pat_data  = 8'h3C;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("c6_done", {31'd0, done},      32'd0);
            chk("c6_sig",  {24'd0, sig},       32'h000000EC);
            chk("c6_wt",   {20'd0, wt_sum},    32'd12);
        end
        chk("c6_hd",   {20'd0, hd_sum},      32'd12);
        chk("c6_hmax", {28'd0, hd_max},      32'd8);
        chk("c6_tm",   {24'd0, toggle_mask}, 32'h000000FF);
        pat_valid = 1'b0;
        @(negedge clk);

        // 3: single pattern after idle gaps
        push_exp(8'hA5, 12'd4, 12'd0, 4'd0, 8'h00);
        start_batch(8'd1);
        repeat (3) begin
            chk("c3_ready_gap", {31'd0, pat_ready}, 32'd1);
            chk("c3_done_gap",  {31'd0, done},      32'd0);
            @(negedge clk);
        end
        send(8'hA5);
        chk("c3_done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // 4: empty batch, second start during DONE ignored
        push_exp(8'h00, 12'd0, 12'd0, 4'd0, 8'h00);
        start     = 1'b1;
        batch_len = 8'd0;
        @(negedge clk);
        chk("c4_ready", {31'd0, pat_ready}, 32'd0);
        chk("c4_done",  {31'd0, done},      32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("c4_done_low", {31'd0, done},      32'd0);
        chk("c4_busy_low", {31'd0, busy},      32'd0);
        chk("c4_ready2",   {31'd0, pat_ready}, 32'd0);
        @(negedge clk);
        chk("c4_no_restart", {31'd0, busy}, 32'd0);

        // 5: reset aborts a batch mid-run, then a fresh batch
        start_batch(8'd4);
        send(8'h0F);
        send(8'hF0);
        #2 rst_n = 1'b0;
        #1;
        chk("c5_rst_busy",  {31'd0, busy},      32'd0);
        chk("c5_rst_ready", {31'd0, pat_ready}, 32'd0);
        chk("c5_rst_sig",   {24'd0, sig},       32'd0);
        chk("c5_rst_wt",    {20'd0, wt_sum},    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("c5_no_done", {31'd0, done}, 32'd0);
        end
        push_exp(8'h01, 12'd3, 12'd1, 4'd1, 8'h02);
        start_batch(8'd2);
        send(8'h01);
        chk("c5_sig_mid", {24'd0, sig}, 32'h00000001);
        send(8'h03);
        chk("c5_done", {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
